// File: rtl/stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_pkg
//  Description : Shared width helpers for the stream FIFO slice. Each stored
//                entry is a packed vector of DATA_W+1 bits. The last flag is
//                the MSB and the payload fills the low DATA_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_fifo_pkg;

    // Number of address bits needed to index DEPTH entries.
    function automatic int ptr_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Width of an occupancy value that must represent 0..DEPTH inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of one stored entry {last, data}.
    function automatic int entry_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage : stream_fifo_pkg
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr_ctrl
//  Description : Read/write pointer and occupancy control for a power-of-two
//                FIFO. Pointers carry one extra wrap bit so that full and
//                empty can be told apart when the address bits match.
//  Ports       : clk, rst_n (async active-low)
//                push, pop   - qualified transfer strobes from the owner
//                flush       - synchronous clear, overrides push/pop
//                rd_addr / wr_addr - storage indices
//                full / empty / count - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl
    import stream_fifo_pkg::*;
#(
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = ptr_addr_w(DEPTH),
    localparam int CNT_W  = level_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            // Pointer width is ADDR_W+1, so natural overflow wraps mod 2*DEPTH.
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    assign rd_addr = rptr[ADDR_W-1:0];
    assign wr_addr = wptr[ADDR_W-1:0];
    assign empty   = (rptr == wptr);
    assign full    = (rptr[ADDR_W-1:0] == wptr[ADDR_W-1:0]) &&
                     (rptr[ADDR_W] != wptr[ADDR_W]);

endmodule : fifo_ptr_ctrl
`default_nettype wire

// File: rtl/stream_last_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_last_fifo
//  Description : First-word-fall-through valid/ready FIFO storing a payload
//                word plus a last flag per entry. It also counts how many
//                complete packets (stored last flags) are buffered.
//  Ports       : clk, rst_n (async active-low), flush_i (sync clear)
//                s_data_i/s_last_i/s_valid_i/s_ready_o - write stream
//                m_data_o/m_last_o/m_valid_o/m_ready_i - read stream
//                full_o, empty_o, almost_full_o, count_o  - occupancy
//                pkt_count_o, pkt_avail_o                 - packet status
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_last_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_THR = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic [DATA_W-1:0]      s_data_i,
    input  logic                   s_last_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    output logic [DATA_W-1:0]      m_data_o,
    output logic                   m_last_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   almost_full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] pkt_count_o,
    output logic                   pkt_avail_o
);

    localparam int ADDR_W = ptr_addr_w(DEPTH);
    localparam int CNT_W  = level_w(DEPTH);

    typedef logic [entry_w(DATA_W)-1:0] entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  pkt_count;

    // Handshakes are qualified only by registered status, so no output has
    // a combinational path from s_valid_i or m_ready_i.
    assign push = s_valid_i & s_ready_o;
    assign pop  = m_valid_o & m_ready_i;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush_i),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .full    (full_o),
        .empty   (empty_o),
        .count   (count_o)
    );

    // Storage is not reset: the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !flush_i) mem[wr_addr] <= {s_last_i, s_data_i};
    end

    assign head      = mem[rd_addr];
    assign m_data_o  = head[DATA_W-1:0];
    assign m_last_o  = head[DATA_W];
    assign m_valid_o = ~empty_o;
    assign s_ready_o = ~full_o;

    // Packet counter: a last flag entering and one leaving in the same
    // cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else if (flush_i) begin
            pkt_count <= '0;
        end else begin
            if ((push && s_last_i) && !(pop && m_last_o))
                pkt_count <= pkt_count + CNT_W'(1);
            else if ((pop && m_last_o) && !(push && s_last_i))
                pkt_count <= pkt_count - CNT_W'(1);
        end
    end

    assign pkt_count_o   = pkt_count;
    assign pkt_avail_o   = |pkt_count;
    assign almost_full_o = (count_o >= CNT_W'(AFULL_THR));

endmodule : stream_last_fifo
`default_nettype wire

// File: tb/tb_stream_last_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_last_fifo
//  Description : Self-checking bench for stream_last_fifo using a queue-based
//                reference model of the buffered entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_last_fifo;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 8;
    localparam int AFULL_THR = 6;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int SW        = 6 + 2 * CW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
    logic              full;
    logic              empty;
    logic              afull;
    logic [CW-1:0]     count;
    logic [CW-1:0]     pkt_count;
    logic              pkt_avail;

    int checks = 0;
    int errors = 0;

    // Reference model: the ordered contents of the FIFO, {last, data} per entry.
    logic [DATA_W:0] q[$];

    always #5 clk = ~clk;

    stream_last_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_THR (AFULL_THR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .s_data_i      (s_data),
        .s_last_i      (s_last),
        .s_valid_i     (s_valid),
        .s_ready_o     (s_ready),
        .m_data_o      (m_data),
        .m_last_o      (m_last),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .full_o        (full),
        .empty_o       (empty),
        .almost_full_o (afull),
        .count_o       (count),
        .pkt_count_o   (pkt_count),
        .pkt_avail_o   (pkt_avail)
    );

    // {empty, valid, full, ready, almost_full, pkt_avail, count, pkt_count}
    function automatic logic [SW-1:0] exp_status();
        int n;
        int p;
        n = q.size();
        p = 0;
        foreach (q[i]) if (q[i][DATA_W]) p++;
        return {n == 0, n != 0, n == DEPTH, n != DEPTH, n >= AFULL_THR, p != 0,
                CW'(n), CW'(p)};
    endfunction

    function automatic logic [SW-1:0] obs_status();
        return {empty, m_valid, full, s_ready, afull, pkt_avail, count, pkt_count};
    endfunction

    // Advance one clock with the current inputs and apply the same transfer
    // rules to the model. Leaves time at posedge+1.
    task automatic tick();
        bit do_push;
        bit do_pop;
        do_push = s_valid && (q.size() < DEPTH);
        do_pop  = m_ready && (q.size() > 0);
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({s_last, s_data});
        end
        #1;
    endtask

    task automatic idle_inputs();
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic clear_fifo();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_status() !== exp_status()) begin
            errors++;
            $display("FAIL reset_status: got %h want %h", obs_status(), exp_status());
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_three_words();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'($urandom);
            s_last  = (i == 2);
            if (i == 0) begin
                checks++;
                if (m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL three_no_bypass: got m_valid=%b want 0", m_valid);
                end
            end
            tick();
            if (i == 0) begin
                checks++;
                if (m_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL three_latency: got m_valid=%b want 1", m_valid);
                end
            end
        end
        s_valid = 1'b0;
        checks++;
        if (obs_status() !== exp_status() || count !== CW'(3) || pkt_count !== CW'(1)) begin
            errors++;
            $display("FAIL three_status: got %h want %h", obs_status(), exp_status());
        end
    endtask

    task automatic test_fill_drain();
        clear_fifo();
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'($urandom);
            s_last  = 1'($urandom);
            tick();
            checks++;
            if (obs_status() !== exp_status()) begin
                errors++;
                $display("FAIL fill_step%0d: got %h want %h", i, obs_status(), exp_status());
            end
        end
        // Ninth word offered while full must be refused.
        s_data = 8'hA5;
        checks++;
        if (s_ready !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: got ready=%b full=%b want 0/1", s_ready, full);
        end
        tick();
        s_valid = 1'b0;
        checks++;
        if (count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL fill_ninth: got count=%0d want %0d", count, DEPTH);
        end
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if ({m_last, m_data} !== q[0]) begin
                errors++;
                $display("FAIL drain_data%0d: got %h want %h", i, {m_last, m_data}, q[0]);
            end
            tick();
        end
        m_ready = 1'b0;
        checks++;
        if (obs_status() !== exp_status() || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: got %h want %h", obs_status(), exp_status());
        end
    endtask

    task automatic test_back_to_back();
        clear_fifo();
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = DATA_W'($urandom);
            s_last = ((i % 4) == 3);
            if (q.size() > 0) begin
                checks++;
                if ({m_last, m_data} !== q[0]) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h want %h", i, {m_last, m_data}, q[0]);
                end
            end
            tick();
            checks++;
            if (count !== CW'(1) || obs_status() !== exp_status()) begin
                errors++;
                $display("FAIL b2b_count%0d: got %h want %h", i, obs_status(), exp_status());
            end
        end
        s_valid = 1'b0;
        checks++;
        if ({m_last, m_data} !== q[0]) begin
            errors++;
            $display("FAIL b2b_tail: got %h want %h", {m_last, m_data}, q[0]);
        end
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        clear_fifo();
        s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_data = DATA_W'($urandom);
            s_last = 1'b0;
            tick();
        end
        m_ready = 1'b1;
        s_data  = 8'h3C;
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        checks++;
        if (count !== CW'(DEPTH - 1) || s_ready !== 1'b1 || obs_status() !== exp_status()) begin
            errors++;
            $display("FAIL full_pop: got %h want %h", obs_status(), exp_status());
        end
    endtask

    task automatic test_pkt_cancel();
        clear_fifo();
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_data  = 8'h11;
        tick();
        m_ready = 1'b1;
        s_data  = 8'h22;
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        checks++;
        if (pkt_count !== CW'(1) || obs_status() !== exp_status()) begin
            errors++;
            $display("FAIL pkt_cancel: got %h want %h", obs_status(), exp_status());
        end
    endtask

    task automatic test_flush();
        clear_fifo();
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = DATA_W'($urandom);
            s_last = (i == 1 || i == 4);
            tick();
        end
        checks++;
        if (count !== CW'(5) || pkt_count !== CW'(2)) begin
            errors++;
            $display("FAIL flush_pre: got count=%0d pkt=%0d want 5/2", count, pkt_count);
        end
        flush  = 1'b1;
        s_last = 1'b1;
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        checks++;
        if (obs_status() !== exp_status() || count !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_post: got %h want %h", obs_status(), exp_status());
        end
    endtask

    task automatic test_random();
        clear_fifo();
        for (int i = 0; i < 300; i++) begin
            s_valid = 1'($urandom);
            m_ready = 1'($urandom);
            s_last  = ($urandom_range(0, 2) == 0);
            s_data  = DATA_W'($urandom);
            flush   = ($urandom_range(0, 24) == 0);
            if (q.size() > 0) begin
                checks++;
                if ({m_last, m_data} !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data%0d: got %h want %h", i, {m_last, m_data}, q[0]);
                end
            end
            tick();
            checks++;
            if (obs_status() !== exp_status()) begin
                errors++;
                $display("FAIL rand_status%0d: got %h want %h", i, obs_status(), exp_status());
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        clear_fifo();
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = DATA_W'($urandom);
            s_last = 1'b1;
            tick();
        end
        // Drop reset between clock edges; outputs must respond without a clock.
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if (obs_status() !== exp_status()) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", obs_status(), exp_status());
        end
        idle_inputs();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_three_words();
        test_fill_drain();
        test_back_to_back();
        test_full_pop();
        test_pkt_cancel();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_stream_last_fifo
`default_nettype wire

// File: doc/stream_last_fifo.md
Name: stream_last_fifo

Overview:
- Parametrised successor to the team's single-bit last-flag FIFO: a first-word-fall-through stream FIFO that stores a DATA_W-bit word plus a last flag per entry.
- Uses valid/ready on both sides and tracks how many complete packets (stored last flags) are buffered.
- Sits between stream producers and packet-oriented consumers that need "a whole packet is present" before arbitrating.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AFULL_THR, 6, almost_full_o asserts when count_o >= AFULL_THR (1..DEPTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of FIFO contents.
- s_data_i  in  DATA_W  write payload.
- s_last_i  in  1  write last flag.
- s_valid_i  in  1  write valid.
- s_ready_o  out  1  write ready (= !full_o).
- m_data_o  out  DATA_W  head payload.
- m_last_o  out  1  head last flag.
- m_valid_o  out  1  head valid (= !empty_o).
- m_ready_i  in  1  read accept.
- full_o  out  1  all DEPTH entries occupied.
- empty_o  out  1  no entries.
- almost_full_o  out  1  count_o >= AFULL_THR.
- count_o  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- pkt_count_o  out  $clog2(DEPTH)+1  stored entries with last=1, 0..DEPTH.
- pkt_avail_o  out  1  pkt_count_o != 0.

Behaviour:
- Reset (async, rst_n low):
  - pointers, count_o and pkt_count_o = 0.
  - empty_o=1, m_valid_o=0, full_o=0, s_ready_o=1, almost_full_o=0, pkt_avail_o=0.
  - Storage array is not reset; outputs are qualified by pointers.
- Pointers: ADDR_W=$clog2(DEPTH). Read/write pointers are ADDR_W+1 bits, with the MSB as the wrap bit.
  - empty: pointers fully equal.
  - full: low bits equal and MSBs differ.
- Push = s_valid_i & s_ready_o. Entry {s_last_i, s_data_i} is written at wptr and wptr increments, wrapping modulo 2*DEPTH.
- Pop = m_valid_i & m_ready_i, i.e. m_valid_o & m_ready_i. rptr increments.
- m_data_o and m_last_o are read combinationally from the entry at rptr (FWFT).
  - Their value is don't-care while m_valid_o=0; the bench must not check them then.
- Latency: a push into an empty FIFO gives m_valid_o=1 on the next cycle. There is no same-cycle bypass.
- Full with simultaneous pop: s_ready_o=0 that cycle, so no push. The FIFO has DEPTH-1 entries next cycle.
- Empty with s_valid_i: push only; m_valid_o stays 0 this cycle.
- Simultaneous push and pop (neither full nor empty): count_o unchanged; both pointers advance.
- count_o: +1 on push only, -1 on pop only, unchanged on both or neither. Registered, never exceeds DEPTH.
- pkt_count_o:
  - +1 when push carries last=1.
  - -1 when pop removes an entry with last=1.
  - unchanged when both events occur together.
  - Registered.
- pkt_avail_o = |pkt_count_o, combinational from the register.
- flush_i (synchronous, highest priority):
  - next cycle: pointers, count_o and pkt_count_o = 0.
  - any push or pop in the flush cycle is discarded.
  - s_ready_o is not gated by flush_i.
- All status outputs derive from registered state; no combinational path from s_valid_i or m_ready_i to any output.

Decomposition:
- Package stream_fifo_pkg:
  - localparam helper function for clog2-based widths.
  - typedef of the entry struct {last, data}, parameterised via DATA_W in the top using a packed logic vector of DATA_W+1 bits.
- Sub-module fifo_ptr_ctrl (parameters DEPTH):
  - inputs: push, pop, flush.
  - outputs: rd/wr addresses, full, empty, count.
- The top holds storage, pkt_count logic and almost_full.

Test Plan:
- Reset, then push 3 words (last on the 3rd) with m_ready_i=0 -> count_o=3, pkt_count_o=1, pkt_avail_o=1. m_valid_o rises 1 cycle after the first push.
- DEPTH=8: push 8 words -> full_o=1, s_ready_o=0, almost_full_o=1 from count 6. A 9th s_valid_i is not accepted. Data pops out in order, then empty_o=1.
- Continuous push and pop with s_valid_i=m_ready_i=1 across 20 words (pointer wrap twice) -> count_o steady at 1. Output sequence equals input sequence; last flags preserved.
- Full FIFO with m_ready_i=1 and s_valid_i=1 in the same cycle -> only a pop occurs, count_o 8->7. Next cycle s_ready_o=1.
- Pop a last=1 entry in the same cycle as pushing a last=1 entry with pkt_count_o=1 -> pkt_count_o stays 1.
- Flush with count_o=5, pkt_count_o=2 and a concurrent push -> next cycle count_o=0, pkt_count_o=0, empty_o=1. The pushed word is lost.
- Assert rst_n low mid-stream -> outputs take reset values immediately (asynchronously).
